// File: rtl/cache_meta_array.sv
// Valid/dirty/tree-PLRU metadata for an N-way set-associative cache.
// Handles one access per cycle and runs a walker for whole-cache and single-line flushes.
module cache_meta_array #(
  parameter int WAYS  = 4,
  parameter int SETS  = 64,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [IDX_W-1:0] req_idx,
  input  logic             req_hit,
  input  logic [WAY_W-1:0] req_way,
  input  logic             req_write,
  input  logic             flush_req,
  input  logic [1:0]       flush_type,
  input  logic [IDX_W-1:0] flush_idx,
  input  logic [WAY_W-1:0] flush_way,
  output logic             rd_valid,
  output logic [WAY_W-1:0] rd_way,
  output logic             rd_evict_dirty,
  output logic             wb_valid,
  output logic [IDX_W-1:0] wb_idx,
  output logic [WAY_W-1:0] wb_way,
  input  logic             wb_ready,
  output logic             busy,
  output logic             flush_done
);

  typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} state_t;

  state_t                   state;
  logic [1:0]               ftype;
  logic [IDX_W-1:0]         scan_idx;
  logic [WAY_W-1:0]         line_way;
  logic [SETS-1:0][WAYS-1:0] valid_q, dirty_q;
  logic [SETS-1:0][WAYS-2:0] plru_q;

  logic             acc;
  logic [WAYS-1:0]  av, ad, av_n, ad_n;
  logic [WAYS-2:0]  ap, ap_n;
  logic             inv_found, ev_dirty, dir;
  logic [WAY_W-1:0] inv_way, plru_way, victim, way_sel;
  int               node;

  logic [WAYS-1:0]  sv, sd, vd;
  logic [WAY_W-1:0] vd_way;
  logic             last_set;

  assign busy = (state == SCAN) || (state == WB);
  assign acc  = req_valid && !busy;

  // Access path: victim choice, PLRU touch and next valid/dirty for req_idx.
  always_comb begin
    av = valid_q[req_idx];
    ad = dirty_q[req_idx];
    ap = plru_q[req_idx];
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS-1; w >= 0; w--)
      if (!av[w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    plru_way = '0;
    node     = 0;
    dir      = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      dir = 1'b0;
      for (int n = 0; n < WAYS-1; n++)
        if (n == node) dir = ~ap[n];
      plru_way[WAY_W-1-l] = dir;
      node = 2*node + (dir ? 2 : 1);
    end
    victim  = inv_found ? inv_way : plru_way;
    way_sel = req_hit ? req_way : victim;
    ap_n = ap;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      dir = way_sel[WAY_W-1-l];
      for (int n = 0; n < WAYS-1; n++)
        if (n == node) ap_n[n] = dir;
      node = 2*node + (dir ? 2 : 1);
    end
    av_n     = av;
    ad_n     = ad;
    ev_dirty = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (WAY_W'(w) == way_sel) begin
        if (req_hit) ad_n[w] = ad[w] | req_write;
        else begin
          av_n[w]  = 1'b1;
          ad_n[w]  = req_write;
          ev_dirty = av[w] & ad[w];
        end
      end
  end

  always_comb begin
    sv = valid_q[scan_idx];
    sd = dirty_q[scan_idx];
    vd = sv & sd;
    vd_way = '0;
    for (int w = WAYS-1; w >= 0; w--)
      if (vd[w]) vd_way = WAY_W'(w);
    last_set = (scan_idx == IDX_W'(SETS-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ftype          <= 2'b00;
      scan_idx       <= '0;
      line_way       <= '0;
      valid_q        <= '0;
      dirty_q        <= '0;
      plru_q         <= '0;
      rd_valid       <= 1'b0;
      rd_way         <= '0;
      rd_evict_dirty <= 1'b0;
      wb_valid       <= 1'b0;
      wb_idx         <= '0;
      wb_way         <= '0;
      flush_done     <= 1'b0;
    end else begin
      rd_valid   <= acc;
      flush_done <= 1'b0;
      if (acc) begin
        rd_way           <= way_sel;
        rd_evict_dirty   <= ev_dirty;
        valid_q[req_idx] <= av_n;
        dirty_q[req_idx] <= ad_n;
        plru_q[req_idx]  <= ap_n;
      end
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (flush_req && flush_type != 2'b00) begin
            state    <= SCAN;
            ftype    <= flush_type;
            scan_idx <= (flush_type == 2'b01) ? flush_idx : '0;
            line_way <= flush_way;
          end
        end
        SCAN: begin
          case (ftype)
            2'b11: begin
              valid_q[scan_idx] <= sv & sd;
              scan_idx <= scan_idx + IDX_W'(1);
              if (last_set) begin
                state      <= DONE;
                flush_done <= 1'b1;
              end
            end
            2'b10: begin
              if (|vd) begin
                state    <= WB;
                wb_valid <= 1'b1;
                wb_idx   <= scan_idx;
                wb_way   <= vd_way;
              end else begin
                valid_q[scan_idx] <= '0;
                dirty_q[scan_idx] <= '0;
                scan_idx <= scan_idx + IDX_W'(1);
                if (last_set) begin
                  state      <= DONE;
                  flush_done <= 1'b1;
                end
              end
            end
            default: begin
              if (sv[line_way] && sd[line_way]) begin
                state    <= WB;
                wb_valid <= 1'b1;
                wb_idx   <= scan_idx;
                wb_way   <= line_way;
              end else begin
                valid_q[scan_idx][line_way] <= 1'b0;
                dirty_q[scan_idx][line_way] <= 1'b0;
                state      <= DONE;
                flush_done <= 1'b1;
              end
            end
          endcase
        end
        WB: begin
          if (wb_ready) begin
            wb_valid                <= 1'b0;
            valid_q[wb_idx][wb_way] <= 1'b0;
            dirty_q[wb_idx][wb_way] <= 1'b0;
            // Whole-cache writeback rescans the same set for further dirty ways.
            if (ftype == 2'b10) state <= SCAN;
            else begin
              state      <= DONE;
              flush_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_meta_array.sv
// Scoreboard bench for cache_meta_array at WAYS=4, SETS=4: access responses,
// flush timing, writeback handshake, dropped requests and reset abort.
module tb_cache_meta_array;
  logic       clk = 0, rst = 1;
  logic       req_valid = 0, req_hit = 0, req_write = 0;
  logic [1:0] req_idx = 0, req_way = 0;
  logic       flush_req = 0;
  logic [1:0] flush_type = 0, flush_idx = 0, flush_way = 0;
  logic       rd_valid, rd_evict_dirty, wb_valid, busy, flush_done;
  logic [1:0] rd_way, wb_idx, wb_way;
  logic       wb_ready = 0;

  cache_meta_array #(.WAYS(4), .SETS(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_idx(req_idx), .req_hit(req_hit),
    .req_way(req_way), .req_write(req_write), .flush_req(flush_req), .flush_type(flush_type),
    .flush_idx(flush_idx), .flush_way(flush_way), .rd_valid(rd_valid), .rd_way(rd_way),
    .rd_evict_dirty(rd_evict_dirty), .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_way(wb_way),
    .wb_ready(wb_ready), .busy(busy), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] way; logic ed; } exp_t;
  exp_t q[$];
  int n_checks = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_valid) begin
      if (q.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("rd_way", 32'(rd_way), 32'(e.way));
        chk("rd_evict_dirty", 32'(rd_evict_dirty), 32'(e.ed));
      end
    end
  end

  task automatic access(input logic [1:0] idx, input logic hit, input logic [1:0] way,
                        input logic wr, input logic [1:0] ew, input logic ed);
    q.push_back('{ew, ed});
    req_valid = 1; req_idx = idx; req_hit = hit; req_way = way; req_write = wr;
    @(posedge clk); #1;
    req_valid = 0; req_hit = 0; req_write = 0;
  endtask

  task automatic start_flush(input logic [1:0] t, input logic [1:0] idx, input logic [1:0] way);
    @(negedge clk);
    flush_req = 1; flush_type = t; flush_idx = idx; flush_way = way;
    @(posedge clk); #1;
    flush_req = 0; flush_type = 0;
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
  endtask

  initial begin
    int done_c, wbcnt, busyc, found, dones;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 0;
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_way", 32'(rd_way), 0);
    chk("rst_rd_evict", 32'(rd_evict_dirty), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_idx", 32'(wb_idx), 0);
    chk("rst_wb_way", 32'(wb_way), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flush_done", 32'(flush_done), 0);

    // Fill set 0, then PLRU-driven victims (back-to-back).
    access(0, 0, 0, 0, 0, 0);
    access(0, 0, 0, 0, 1, 0);
    access(0, 0, 0, 0, 2, 0);
    access(0, 0, 0, 0, 3, 0);
    access(0, 0, 0, 0, 0, 0);
    access(0, 1, 0, 1, 0, 0);
    access(0, 0, 0, 0, 2, 0);
    access(0, 0, 0, 0, 1, 0);
    access(0, 0, 0, 0, 3, 0);
    access(0, 0, 0, 0, 0, 1);
    drain();

    // Type 10 with a single dirty line in set 2.
    access(2, 0, 0, 1, 0, 0);
    drain();
    wb_ready = 1;
    start_flush(2'b10, 0, 0);
    done_c = 0; wbcnt = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (wb_valid) begin
        wbcnt++;
        chk("f10_wb_idx", 32'(wb_idx), 2);
        chk("f10_wb_way", 32'(wb_way), 0);
      end
      if (flush_done) begin done_c = c; break; end
    end
    chk("f10_done_cycle", 32'(done_c), 7);
    chk("f10_wb_count", 32'(wbcnt), 1);
    wb_ready = 0;
    #1;
    access(2, 0, 0, 0, 0, 0);
    access(0, 0, 0, 0, 0, 0);
    drain();

    // Type 11 with dirty way 0 and clean way 1 in set 1.
    access(1, 0, 0, 1, 0, 0);
    access(1, 0, 0, 0, 1, 0);
    drain();
    start_flush(2'b11, 0, 0);
    done_c = 0; busyc = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (busy) busyc++;
      if (flush_done) begin done_c = c; break; end
    end
    chk("f11_busy_cycles", 32'(busyc), 4);
    chk("f11_done_cycle", 32'(done_c), 5);
    #1;
    access(1, 0, 0, 0, 1, 0);
    access(2, 0, 0, 0, 0, 0);
    drain();

    // Type 01 on dirty set 1 way 0, wb_ready held low for 3 cycles.
    start_flush(2'b01, 1, 0);
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (wb_valid) found = 1;
    end
    chk("f01_wb_seen", 32'(found), 1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("f01_wb_hold", 32'(wb_valid), 1);
      chk("f01_wb_idx", 32'(wb_idx), 1);
      chk("f01_wb_way", 32'(wb_way), 0);
      chk("f01_no_done", 32'(flush_done), 0);
    end
    wb_ready = 1;
    @(posedge clk); #1; wb_ready = 0;
    @(negedge clk);
    chk("f01_wb_drop", 32'(wb_valid), 0);
    chk("f01_done", 32'(flush_done), 1);
    @(negedge clk);
    chk("f01_done_pulse", 32'(flush_done), 0);
    chk("f01_idle", 32'(busy), 0);
    access(1, 0, 0, 0, 0, 0);
    drain();

    // Requests during busy are dropped; the monitor flags any rd_valid.
    start_flush(2'b11, 0, 0);
    req_valid = 1; req_idx = 3; req_hit = 0;
    repeat (3) @(posedge clk);
    #1; req_valid = 0;
    done_c = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (flush_done) begin done_c = 1; break; end
    end
    chk("drop_flush_done", 32'(done_c), 1);
    drain();

    // Reset while waiting in WB.
    access(3, 0, 0, 1, 0, 0);
    drain();
    start_flush(2'b01, 3, 0);
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (wb_valid) found = 1;
    end
    chk("rstwb_wb_seen", 32'(found), 1);
    rst = 1;
    @(posedge clk); #1;
    chk("rstwb_busy", 32'(busy), 0);
    chk("rstwb_wb_valid", 32'(wb_valid), 0);
    @(posedge clk); #1;
    rst = 0;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (flush_done) dones++;
    end
    chk("rstwb_no_done", 32'(dones), 0);
    #1;
    access(1, 0, 0, 0, 0, 0);
    access(3, 0, 0, 0, 0, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
